// File: rtl/logic_operand_loader.sv
// Operand-entry stage for the logical unit: steps op select / X / Y / Z capture
// from switches, one debounced key press per step, then pulses issue.
// Ports: clk, rst (async, active-high), sw_data, key_n, abort in;
//   op_sel, x_out, y_out, z_out, issue, busy, state_out out.
// Optional: define LOADER_DEBOUNCE_EN to add a stable-count key filter.
module logic_operand_loader #(
  parameter int DATA_W          = 4,
  parameter int NOT_W           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOT_W-1:0]  sw_data,
  input  logic              key_n,
  input  logic              abort,
  output logic [1:0]        op_sel,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [NOT_W-1:0]  z_out,
  output logic              issue,
  output logic              busy,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    ST_OP   = 2'd0,
    ST_X    = 2'd1,
    ST_Y    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   level;
  logic                   press;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], key_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Filtered level follows the synchronizer only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q + 1'b1 == CNT_MAX) begin
        filt_d = sync_q[SYNC_STAGES-1];
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  logic unused_dbc;
  assign unused_dbc = ^DEBOUNCE_CYCLES;
  assign level      = sync_q[SYNC_STAGES-1];
`endif

  assign hist_d = level;
  assign press  = hist_q & ~level;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [NOT_W-1:0]  z_q, z_d;
  logic              issue_q, issue_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    issue_d = 1'b0;
    if (abort) begin
      state_d = ST_OP;
      op_d    = '0;
      x_d     = '0;
      y_d     = '0;
      z_d     = '0;
    end else if (press) begin
      unique case (state_q)
        ST_OP: begin
          op_d    = sw_data[1:0];
          state_d = ST_X;
        end
        ST_X: begin
          if (op_q == 2'b11) begin
            z_d     = sw_data;
            issue_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            x_d     = sw_data[DATA_W-1:0];
            state_d = ST_Y;
          end
        end
        ST_Y: begin
          y_d     = sw_data[DATA_W-1:0];
          issue_d = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_OP;
        default: state_d = ST_OP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OP;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      issue_q <= issue_d;
    end
  end

  assign op_sel    = op_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign issue     = issue_q;
  assign busy      = (state_q == ST_X) | (state_q == ST_Y);
  assign state_out = state_q;

endmodule

// File: tb/tb_logic_operand_loader.sv
// Directed bench for logic_operand_loader (default build, no debouncer).
// Hand-computed expectations; one check task, one summary line.
module tb_logic_operand_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_data = '0;
  logic       key_n = 1'b1;
  logic       abort = 1'b0;
  logic [1:0] op_sel;
  logic [3:0] x_out, y_out;
  logic [7:0] z_out;
  logic       issue, busy;
  logic [1:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;
  int issue_cnt = 0;
  int consec = 0;
  logic prev_issue = 1'b0;
  logic [3:0] y_at_issue = '0;
  logic [7:0] z_at_issue = '0;

  logic_operand_loader dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .key_n(key_n),
    .abort(abort), .op_sel(op_sel), .x_out(x_out), .y_out(y_out),
    .z_out(z_out), .issue(issue), .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (issue) begin
      issue_cnt++;
      y_at_issue = y_out;
      z_at_issue = z_out;
      if (prev_issue) consec++;
    end
    prev_issue = issue;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] v);
    @(posedge clk); #1;
    sw_data = v;
    key_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_state", state_out, 0);
    chk("rst_op", op_sel, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issue", issue_cnt, 0);

    step(8'h01);
    chk("or_s1", state_out, 1);
    chk("or_op", op_sel, 1);
    chk("or_busy1", busy, 1);
    step(8'h0A);
    chk("or_s2", state_out, 2);
    chk("or_x", x_out, 4'hA);
    chk("or_busy2", busy, 1);
    step(8'h05);
    chk("or_s3", state_out, 3);
    chk("or_y", y_out, 4'h5);
    chk("or_busy3", busy, 0);
    chk("or_issue_n", issue_cnt, 1);
    chk("or_issue_y", y_at_issue, 4'h5);
    step(8'hFF);
    chk("done_s0", state_out, 0);
    chk("done_op", op_sel, 1);
    chk("done_x", x_out, 4'hA);
    chk("done_y", y_out, 4'h5);

    step(8'h03);
    chk("not_op", op_sel, 3);
    step(8'hC5);
    chk("not_s3", state_out, 3);
    chk("not_z", z_out, 8'hC5);
    chk("not_issue_n", issue_cnt, 2);
    chk("not_issue_z", z_at_issue, 8'hC5);
    chk("not_y_keep", y_out, 4'h5);
    chk("not_x_keep", x_out, 4'hA);
    step(8'h00);
    chk("not_ret_s0", state_out, 0);
    chk("not_ret_z", z_out, 8'hC5);

    step(8'h00);
    step(8'h07);
    chk("ab_pre_s2", state_out, 2);
    chk("ab_pre_x", x_out, 4'h7);
    @(posedge clk); #1;
    sw_data = 8'h0F;
    key_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("ab_state", state_out, 0);
    chk("ab_op", op_sel, 0);
    chk("ab_x", x_out, 0);
    chk("ab_y", y_out, 0);
    chk("ab_z", z_out, 0);
    repeat (5) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("ab_state2", state_out, 0);
    chk("ab_issue_n", issue_cnt, 2);

    @(posedge clk); #1;
    sw_data = 8'h02;
    key_n = 1'b0;
    @(posedge clk); #1;
    chk("lat_e1", state_out, 0);
    @(posedge clk); #1;
    chk("lat_e2", state_out, 0);
    @(posedge clk); #1;
    chk("lat_e3", state_out, 1);
    chk("lat_op", op_sel, 2);
    repeat (100) @(posedge clk);
    #1;
    chk("hold_one", state_out, 1);
    key_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    step(8'h09);
    chk("ar_pre_s2", state_out, 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", state_out, 0);
    chk("ar_op", op_sel, 0);
    chk("ar_x", x_out, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("ar_issue_n", issue_cnt, 2);
    chk("no_consec", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
